// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time through an external registered ALU and
// holds the captured result until the downstream consumer takes it.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     cmd_a,
    input  logic [DATA_WIDTH-1:0]     cmd_b,
    input  logic [2:0]                cmd_op,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [2:0]                alu_op,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic [2:0]                rsp_op,
    output logic                      rsp_zero,
    output logic [15:0]               op_count,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid holders keep payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t     state;
    logic [2:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 3'd0;
            rsp_data <= '0;
            rsp_op   <= 3'd0;
            rsp_zero <= 1'b0;
            op_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a    <= cmd_a;
                        alu_b    <= cmd_b;
                        alu_op   <= cmd_op;
                        wait_cnt <= LAT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // One extra edge after the count expires lets the ALU
                    // register settle before the result is captured.
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        rsp_data <= alu_result;
                        rsp_op   <= alu_op;
                        rsp_zero <= (alu_result == '0);
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand width; result width SHALL be 2*DATA_WIDTH.
REQ-002 Parameter LATENCY, default 1, ALU result latency in clk edges after operands are sampled; legal range 1..7.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream command valid.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_a  input  DATA_WIDTH  operand A.
REQ-008 cmd_b  input  DATA_WIDTH  operand B.
REQ-009 cmd_op  input  3  ALU opcode (0 add, 1 sub, 2 xor, 3 and, 4 or, 5 mul, 6 shl, 7 shr).
REQ-010 alu_a  output  DATA_WIDTH  registered operand A to ALU.
REQ-011 alu_b  output  DATA_WIDTH  registered operand B to ALU.
REQ-012 alu_op  output  3  registered opcode to ALU.
REQ-013 alu_result  input  2*DATA_WIDTH  registered ALU result.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  downstream accepts response.
REQ-016 rsp_data  output  2*DATA_WIDTH  captured ALU result.
REQ-017 rsp_op  output  3  opcode of the response.
REQ-018 rsp_zero  output  1  high when rsp_data == 0.
REQ-019 op_count  output  16  completed-response counter.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, WAIT and RESP; cmd_ready SHALL equal (state == IDLE).
REQ-022 Accept: cmd_valid & cmd_ready at edge E0 -> alu_a/alu_b/alu_op load cmd_a/cmd_b/cmd_op, wait counter loads LATENCY, state -> WAIT.
REQ-023 WAIT, counter != 0: counter decrements each edge.
REQ-024 WAIT, counter == 0: at that edge rsp_data <= alu_result, rsp_op <= alu_op, rsp_zero <= (alu_result == 0), state -> RESP.
REQ-025 rsp_valid SHALL equal (state == RESP) and SHALL first be high LATENCY+1 edges after E0 (2 cycles at LATENCY=1).
REQ-026 RESP: rsp_data, rsp_op and rsp_zero SHALL stay stable until rsp_valid & rsp_ready.
REQ-027 On rsp_valid & rsp_ready: op_count increments by 1, state -> IDLE; rsp_ready already high on entry completes the handshake in the first RESP cycle.
REQ-028 op_count SHALL wrap 0xFFFF -> 0x0000 without other side effect.
REQ-029 cmd_valid outside IDLE SHALL be ignored; no command is queued or dropped silently, since upstream holds it per valid/ready.
REQ-030 alu_a/alu_b/alu_op SHALL hold their last values after a transaction until the next accept.
REQ-031 alu_result is sampled only at the REQ-024 edge; changes at other times SHALL have no effect.
REQ-032 Minimum transaction period SHALL be LATENCY+3 cycles: accept, LATENCY+1 wait edges, and one RESP cycle with rsp_ready high.

Reset
REQ-033 rst high at an edge SHALL force state IDLE, counter 0, alu_a/alu_b/alu_op 0, rsp_data 0, rsp_op 0, rsp_zero 0, op_count 0.
REQ-034 After reset, rsp_valid = 0, busy = 0, cmd_ready = 1.
REQ-035 rst in WAIT or RESP SHALL discard the in-flight result: no rsp_valid pulse, op_count stays 0.
REQ-036 rst has priority over a simultaneous cmd or rsp handshake; that handshake SHALL NOT take effect.

Verification
REQ-037 Reset: hold rst 2 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=1, no accept during reset.
REQ-038 Add: A=0x0003, B=0x0004, op=0, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x00000007, rsp_zero=0, op_count=1.
REQ-039 Backpressure: A=0x00FF, B=0x0100, op=5, rsp_ready low 3 cycles -> rsp_data=0x0000FF00 held stable, cmd_ready=0, a second cmd_valid not accepted; rsp_ready high -> op_count increments once.
REQ-040 Zero flag: A=B=0x1234, op=2 -> rsp_data=0, rsp_zero=1; then A=0x0001, B=0x0002, op=1 -> rsp_data=0xFFFFFFFF, rsp_zero=0.
REQ-041 Reset mid-op: accept op=0, assert rst in WAIT -> next cycle IDLE, rsp_valid never asserts, op_count=0.
REQ-042 Wrap: 65536 back-to-back transactions -> op_count=0x0000; one more -> 0x0001.
